// File: rtl/buffer_pkg.sv
// buffer_pkg: shared state encoding, status bit positions and default sizes
package buffer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DRAIN = 2'd2} state_t;
  localparam int ST_IDLE = 0;
  localparam int ST_PLAY = 1;
  localparam int ST_REJECT = 2;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_HOLD = 4;
endpackage

// File: rtl/next_valid_idx.sv
// next_valid_idx: finds the next set valid bit strictly above ptr, wrapping around
module next_valid_idx #(
  parameter int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  logic [IDX_W-1:0] j;
  // Scan from farthest to nearest so the nearest hit wins; i == DEPTH revisits ptr itself
  always_comb begin
    idx = '0;
    found = 1'b0;
    j = '0;
    for (int i = DEPTH; i >= 1; i--) begin
      j = ptr + IDX_W'(i);
      if (valid[j]) begin
        idx = j;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/buffer_seq_ctrl.sv
// buffer_seq_ctrl: switch-loaded slot buffer with idle preview and timed playback sequencing
module buffer_seq_ctrl
  import buffer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int HOLD_CYCLES = DEF_HOLD,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic [IDX_W-1:0]  bufferIndex,
  input  logic              submit,
  input  logic              mode,
  output logic [DATA_W-1:0] out,
  output logic [2:0]        status,
  output logic              busy
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);
  state_t state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid, valid_nx;
  logic submit_q, sub_edge, wr, sticky, found;
  logic [CW-1:0] cnt;
  logic [IDX_W-1:0] ptr, nxt;
  logic [DATA_W-1:0] nxt_data;
  assign sub_edge = submit & ~submit_q;
  assign wr = sub_edge && state == IDLE;
  assign valid_nx = valid | (wr ? DEPTH'(1) << bufferIndex : '0);
  // In IDLE search from DEPTH-1 so the wrap lands on the lowest valid slot, including one being written now
  next_valid_idx #(.DEPTH(DEPTH)) u_nxt (
    .valid(state == IDLE ? valid_nx : valid),
    .ptr(state == IDLE ? IDX_W'(DEPTH - 1) : ptr),
    .idx(nxt),
    .found(found)
  );
  assign nxt_data = (wr && nxt == bufferIndex) ? data : mem[nxt];
  assign status[ST_IDLE] = state == IDLE;
  assign status[ST_PLAY] = state != IDLE;
  assign status[ST_REJECT] = sticky;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      valid <= '0;
      submit_q <= 1'b0;
      state <= IDLE;
      out <= '0;
      cnt <= '0;
      ptr <= '0;
      sticky <= 1'b0;
    end else begin
      submit_q <= submit;
      valid <= valid_nx;
      if (wr) mem[bufferIndex] <= data;
      if (state == IDLE) begin
        out <= wr ? data : mem[bufferIndex];
        if (mode && found) begin
          state <= PLAY;
          ptr <= nxt;
          out <= nxt_data;
          cnt <= RELOAD;
        end else if (mode) sticky <= 1'b1;
      end else begin
        if (sub_edge) sticky <= 1'b1;
        if (state == DRAIN && !mode && cnt == '0) state <= IDLE;
        else begin
          state <= mode ? PLAY : DRAIN;
          if (cnt == '0) begin
            ptr <= nxt;
            out <= nxt_data;
            cnt <= RELOAD;
          end else cnt <= cnt - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_buffer_seq_ctrl.sv
// tb_buffer_seq_ctrl: directed vector table plus hand sequences for drain and reset corner cases
module tb_buffer_seq_ctrl;
  logic clk = 1'b0;
  logic reset, submit, mode;
  logic [3:0] data, out;
  logic [1:0] bufferIndex;
  logic [2:0] status;
  logic busy;
  int n_run = 0;
  int n_fail = 0;
  typedef struct {
    logic       rst;
    logic [3:0] data;
    logic [1:0] idx;
    logic       sub;
    logic       mode;
    logic [3:0] eout;
    logic [2:0] est;
    string      name;
  } vec_t;
  vec_t vecs[$];
  logic [3:0] play_vals [3] = '{4'h3, 4'hC, 4'h5};

  buffer_seq_ctrl #(.DATA_W(4), .DEPTH(4), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .data(data), .bufferIndex(bufferIndex),
    .submit(submit), .mode(mode), .out(out), .status(status), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] d, input logic [1:0] i, input logic s,
                     input logic m, input logic [3:0] eo, input logic [2:0] es, input string nm);
    vec_t v;
    v.rst = r; v.data = d; v.idx = i; v.sub = s; v.mode = m; v.eout = eo; v.est = es; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic [3:0] d, input logic [1:0] i, input logic s,
                      input logic m, input logic [3:0] eo, input logic [2:0] es, input string nm);
    @(negedge clk);
    reset = r; data = d; bufferIndex = i; submit = s; mode = m;
    @(posedge clk);
    #1;
    n_run++;
    if (out !== eo || status !== es || busy !== es[1]) begin
      n_fail++;
      $display("FAIL %s: out=%h status=%b busy=%b, expected out=%h status=%b busy=%b",
               nm, out, status, busy, eo, es, es[1]);
    end
  endtask

  initial begin
    reset = 1'b1; data = '0; bufferIndex = '0; submit = 1'b0; mode = 1'b0;
    add(1, 4'h0, 2, 0, 0, 4'h0, 3'b001, "reset");
    add(0, 4'h0, 2, 0, 0, 4'h0, 3'b001, "idle_preview_empty");
    add(0, 4'h0, 2, 0, 1, 4'h0, 3'b101, "mode_empty_reject");
    add(0, 4'h0, 2, 0, 0, 4'h0, 3'b101, "reject_sticky");
    add(1, 4'h0, 2, 0, 0, 4'h0, 3'b001, "reset_clears_reject");
    add(0, 4'hA, 2, 1, 0, 4'hA, 3'b001, "submit_write_through");
    for (int k = 0; k < 4; k++) add(0, 4'h7, 2, 1, 0, 4'hA, 3'b001, "submit_held_once");
    add(0, 4'h3, 0, 0, 0, 4'h0, 3'b001, "preview_slot0_empty");
    add(0, 4'h3, 0, 1, 0, 4'h3, 3'b001, "load_slot0");
    add(0, 4'h0, 2, 0, 0, 4'hA, 3'b001, "preview_slot2");
    add(0, 4'hC, 2, 1, 0, 4'hC, 3'b001, "load_slot2");
    add(0, 4'h0, 1, 0, 0, 4'h0, 3'b001, "preview_slot1_empty");
    add(0, 4'h5, 3, 1, 0, 4'h5, 3'b001, "load_slot3");
    add(0, 4'h0, 3, 0, 0, 4'h5, 3'b001, "preview_slot3");
    for (int k = 0; k < 14; k++) add(0, 4'h0, 3, 0, 1, play_vals[(k / 4) % 3], 3'b010, "playback_seq");
    foreach (vecs[k])
      step(vecs[k].rst, vecs[k].data, vecs[k].idx, vecs[k].sub, vecs[k].mode, vecs[k].eout, vecs[k].est, vecs[k].name);
    // Second round of slot0 is mid-hold here; a submit must be rejected and slot1 stay skipped
    step(0, 4'hF, 1, 1, 1, 4'h3, 3'b110, "play_submit_reject");
    step(0, 4'hF, 1, 0, 1, 4'h3, 3'b110, "play_slot0_end");
    step(0, 4'h0, 1, 0, 1, 4'hC, 3'b110, "play_skip_slot1");
    step(0, 4'h0, 1, 0, 1, 4'hC, 3'b110, "play_slot2_c2");
    step(0, 4'h0, 1, 0, 0, 4'hC, 3'b110, "drain_c3");
    step(0, 4'h0, 1, 0, 0, 4'hC, 3'b110, "drain_c4");
    step(0, 4'h0, 1, 0, 0, 4'hC, 3'b101, "drain_to_idle");
    step(0, 4'h0, 1, 0, 0, 4'h0, 3'b101, "preview_slot1_unwritten");
    step(0, 4'h0, 2, 0, 0, 4'hC, 3'b101, "preview_resumed");
    step(0, 4'h0, 2, 0, 1, 4'h3, 3'b110, "replay_entry");
    step(0, 4'h0, 2, 0, 1, 4'h3, 3'b110, "replay_hold");
    step(1, 4'h0, 2, 0, 1, 4'h0, 3'b001, "reset_mid_play");
    step(0, 4'h0, 2, 0, 1, 4'h0, 3'b101, "mode_after_reset_reject");
    step(0, 4'h0, 0, 0, 0, 4'h0, 3'b101, "slot0_cleared");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
